// File: rtl/blip_pkg.sv
// blip_pkg: shared types and helpers for the blip scheduler.
package blip_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    HOLD
  } state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blip_req_sync.sv
// blip_req_sync: 2-flop synchronizer plus rising-edge detect
// for one asynchronous level request.
module blip_req_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic req,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= req;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/blip_scheduler.sv
// blip_scheduler: latches request edges as pending events and
// issues them round-robin as spaced single-cycle blips.
module blip_scheduler
  import blip_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GAP   = 2,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req_in,
  input  logic             enable,
  output logic             blip_out,
  output logic [ID_W-1:0]  blip_id,
  output logic [N_REQ-1:0] pending,
  output logic             overrun
);

  localparam logic [7:0] GAP_LD =
    (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t           state;
  state_t           nxt;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] pend_nxt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win;
  logic [ID_W:0]    idx;
  logic [7:0]       cnt;
  logic [7:0]       cnt_nxt;
  logic             fire_nxt;
  logic             ovr_nxt;

  for (genvar g = 0; g < N_REQ; g++) begin : g_sync
    blip_req_sync u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req_in[g]),
      .rise    (rise[g])
    );
  end

  // Scan downward so the nearest set bit after ptr wins.
  always_comb begin
    win = ptr;
    idx = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = {1'b0, ptr} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(N_REQ))
        idx = idx - (ID_W+1)'(N_REQ);
      if (pending[idx[ID_W-1:0]])
        win = idx[ID_W-1:0];
    end
  end

  // A fresh edge on the bit being granted re-arms it silently.
  always_comb begin
    grant = '0;
    if (state == FIRE)
      grant[blip_id] = 1'b1;
    pend_nxt = (pending & ~grant) | rise;
    ovr_nxt  = |(rise & pending & ~grant);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (enable && |pending) nxt = FIRE;
      FIRE: nxt = (GAP > 0) ? HOLD : IDLE;
      HOLD: if (cnt == 8'd0) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    fire_nxt = (nxt == FIRE);
    cnt_nxt  = cnt;
    if (state == FIRE)
      cnt_nxt = GAP_LD;
    else if (state == HOLD && cnt != 8'd0)
      cnt_nxt = cnt - 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blip_out <= 1'b0;
      blip_id  <= '0;
      ptr      <= ID_W'(N_REQ - 1);
      cnt      <= 8'd0;
      pending  <= '0;
      overrun  <= 1'b0;
    end else begin
      blip_out <= fire_nxt;
      pending  <= pend_nxt;
      overrun  <= ovr_nxt;
      cnt      <= cnt_nxt;
      if (fire_nxt) begin
        blip_id <= win;
        ptr     <= win;
      end
    end
  end

endmodule
